// File: rtl/formula_result_credit_buffer.sv
// Output stage for the a**5 + 0.3*b - c pipeline. Buffers results in a FIFO
// and throttles upstream launches with an occupancy credit so that no result
// already inside the non-stallable pipeline can ever be dropped.
module formula_result_credit_buffer #(
  parameter int unsigned FLEN    = 64,
  parameter int unsigned LATENCY = 16,
  parameter int unsigned DEPTH   = LATENCY + 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_arg_vld,
  output logic            o_arg_rdy,
  input  logic            i_pipe_res_vld,
  input  logic [FLEN-1:0] i_pipe_res,
  output logic            o_res_vld,
  input  logic            i_res_rdy,
  output logic [FLEN-1:0] o_res,
  output logic            o_err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [CW-1:0]   r_occ;
  logic [CW-1:0]   r_fcnt;
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic            r_err;
  logic [FLEN-1:0] r_mem [DEPTH];

  logic [CW-1:0] w_occ_nxt;
  logic [CW-1:0] w_fcnt_nxt;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic          w_err_nxt;
  logic [CW-1:0] w_in_flight;
  logic          w_launch;
  logic          w_pop;
  logic          w_push;
  logic          w_unexpected;

  // Handshake decode; arg_rdy and res_vld come from registered state only
  always_comb begin
    o_arg_rdy    = (r_occ != DEPTH_C);
    o_res_vld    = (r_fcnt != '0);
    o_res        = r_mem[r_rd_ptr];
    o_err        = r_err;
    w_in_flight  = r_occ - r_fcnt;
    w_launch     = i_arg_vld & o_arg_rdy;
    w_pop        = o_res_vld & i_res_rdy;
    // A result with nothing in flight has no credit behind it: drop it and flag
    w_push       = i_pipe_res_vld & (w_in_flight != '0);
    w_unexpected = i_pipe_res_vld & (w_in_flight == '0);
  end

  // Next-state for credit, fill level, pointers and sticky error
  always_comb begin
    w_occ_nxt = r_occ;
    if (w_launch && !w_pop) begin
      w_occ_nxt = r_occ + CW'(1);
    end else if (w_pop && !w_launch) begin
      w_occ_nxt = r_occ - CW'(1);
    end

    w_fcnt_nxt = r_fcnt;
    if (w_push && !w_pop) begin
      w_fcnt_nxt = r_fcnt + CW'(1);
    end else if (w_pop && !w_push) begin
      w_fcnt_nxt = r_fcnt - CW'(1);
    end

    w_wr_ptr_nxt = r_wr_ptr;
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
    end

    w_rd_ptr_nxt = r_rd_ptr;
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);
    end

    w_err_nxt = r_err | w_unexpected;
  end

  // Control state register with asynchronous active-low reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_occ    <= '0;
      r_fcnt   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_occ    <= w_occ_nxt;
      r_fcnt   <= w_fcnt_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Result storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_pipe_res;
    end
  end

endmodule
